// File: rtl/operand_fork_axi_pkg.sv
// Shared constants and types for the MAC operand fork.
package operand_fork_axi_pkg;

    localparam int unsigned DW_DEFAULT = 8;
    localparam int unsigned CW_DEFAULT = 16;
    localparam int unsigned NUM_LANES  = 4;

    localparam int unsigned LANE_A = 0;
    localparam int unsigned LANE_B = 1;
    localparam int unsigned LANE_C = 2;
    localparam int unsigned LANE_D = 3;

    typedef enum logic {
        StEmpty,
        StFull
    } lane_state_e;

endpackage

// File: rtl/operand_fork_axi_fork_lane.sv
// One output slot of the operand fork: a data register plus a valid bit.
module operand_fork_axi_fork_lane
    import operand_fork_axi_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] din,
    input  logic          ready,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic          free
);

    lane_state_e   state_q, state_d;
    logic [DW-1:0] data_q;

    // The parent only asserts load when every lane is free, so a stalled
    // FULL lane never sees load and holds its data and valid.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (load) state_d = StFull;
            StFull:  if (ready && !load) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StEmpty;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) data_q <= din;
        end
    end

    assign dout  = data_q;
    assign valid = (state_q == StFull);
    assign free  = ~valid | ready;

endmodule

// File: rtl/operand_fork_axi.sv
// Forks one packed {D,C,B,A} beat into four independent valid/ready operand streams.
module operand_fork_axi
    import operand_fork_axi_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned CW = CW_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DW-1:0]     s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [DW-1:0]       A,
    output logic [DW-1:0]       B,
    output logic [DW-1:0]       C,
    output logic [DW-1:0]       D,
    output logic                a_valid,
    output logic                b_valid,
    output logic                c_valid,
    output logic                d_valid,
    input  logic                a_ready,
    input  logic                b_ready,
    input  logic                c_ready,
    input  logic                d_ready,
    output logic [CW-1:0]       accept_cnt,
    output logic                busy
);

    logic [NUM_LANES-1:0] lane_ready;
    logic [NUM_LANES-1:0] lane_valid;
    logic [NUM_LANES-1:0] lane_free;
    logic [DW-1:0]        lane_data [NUM_LANES];
    logic                 accept;
    logic [CW-1:0]        cnt_q;

    assign lane_ready[LANE_A] = a_ready;
    assign lane_ready[LANE_B] = b_ready;
    assign lane_ready[LANE_C] = c_ready;
    assign lane_ready[LANE_D] = d_ready;

    // Depends only on lane state and readys, never on s_valid.
    assign s_ready = reset & (&lane_free);
    assign accept  = s_valid & s_ready;

    for (genvar i = 0; i < NUM_LANES; i++) begin : gen_lane
        operand_fork_axi_fork_lane #(
            .DW(DW)
        ) u_lane (
            .clk  (clk),
            .reset(reset),
            .load (accept),
            .din  (s_data[i*DW +: DW]),
            .ready(lane_ready[i]),
            .dout (lane_data[i]),
            .valid(lane_valid[i]),
            .free (lane_free[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign A       = lane_data[LANE_A];
    assign B       = lane_data[LANE_B];
    assign C       = lane_data[LANE_C];
    assign D       = lane_data[LANE_D];
    assign a_valid = lane_valid[LANE_A];
    assign b_valid = lane_valid[LANE_B];
    assign c_valid = lane_valid[LANE_C];
    assign d_valid = lane_valid[LANE_D];

    assign accept_cnt = cnt_q;
    assign busy       = |lane_valid;

endmodule

// File: tb/tb_operand_fork_axi.sv
// Directed self-checking bench for operand_fork_axi (DW=8, CW=16).
module tb_operand_fork_axi;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;

    logic            clk;
    logic            reset;
    logic [4*DW-1:0] s_data;
    logic            s_valid;
    logic            s_ready;
    logic [DW-1:0]   A, B, C, D;
    logic            a_valid, b_valid, c_valid, d_valid;
    logic            a_ready, b_ready, c_ready, d_ready;
    logic [CW-1:0]   accept_cnt;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    operand_fork_axi #(
        .DW(DW),
        .CW(CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .c_valid   (c_valid),
        .d_valid   (d_valid),
        .a_ready   (a_ready),
        .b_ready   (b_ready),
        .c_ready   (c_ready),
        .d_ready   (d_ready),
        .accept_cnt(accept_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_readys(input logic [3:0] r);
        {d_ready, c_ready, b_ready, a_ready} = r;
    endtask

    task automatic check_lanes(input string tag, input logic [3:0] vld,
                               input logic [7:0] ea, input logic [7:0] eb,
                               input logic [7:0] ec, input logic [7:0] ed);
        check({tag, " valids"}, {28'd0, d_valid, c_valid, b_valid, a_valid}, {28'd0, vld});
        check({tag, " A"}, {24'd0, A}, {24'd0, ea});
        check({tag, " B"}, {24'd0, B}, {24'd0, eb});
        check({tag, " C"}, {24'd0, C}, {24'd0, ec});
        check({tag, " D"}, {24'd0, D}, {24'd0, ed});
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        set_readys(4'hF);
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        set_readys(4'hF);

        // 1: reset state, then a single beat
        tick();
        tick();
        check("rst s_ready", {31'd0, s_ready}, 32'd0);
        check_lanes("rst", 4'h0, 8'd0, 8'd0, 8'd0, 8'd0);
        check("rst cnt", {16'd0, accept_cnt}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        reset   = 1'b1;
        s_data  = 32'h02010302;
        s_valid = 1'b1;
        #1;
        check("t1 s_ready", {31'd0, s_ready}, 32'd1);
        tick();
        s_valid = 1'b0;
        check_lanes("t1 beat", 4'hF, 8'd2, 8'd3, 8'd1, 8'd2);
        check("t1 cnt", {16'd0, accept_cnt}, 32'd1);
        check("t1 busy", {31'd0, busy}, 32'd1);
        tick();
        check_lanes("t1 drained", 4'h0, 8'd2, 8'd3, 8'd1, 8'd2);
        check("t1 busy off", {31'd0, busy}, 32'd0);

        // 2: ten back-to-back beats
        do_reset();
        for (int i = 0; i < 10; i++) begin
            s_data  = {8'(4 + 2*i), 8'(2 + i), 8'(6 + 3*i), 8'(4 + 2*i)};
            s_valid = 1'b1;
            #1;
            check($sformatf("t2 s_ready %0d", i), {31'd0, s_ready}, 32'd1);
            tick();
            check_lanes($sformatf("t2 beat %0d", i), 4'hF,
                        8'(4 + 2*i), 8'(6 + 3*i), 8'(2 + i), 8'(4 + 2*i));
        end
        s_valid = 1'b0;
        tick();
        check("t2 cnt", {16'd0, accept_cnt}, 32'd10);
        check("t2 idle", {28'd0, d_valid, c_valid, b_valid, a_valid}, 32'd0);

        // 3: C stalls for three cycles with a second beat pending
        do_reset();
        s_data  = 32'h44332211;
        s_valid = 1'b1;
        tick();
        check_lanes("t3 first", 4'hF, 8'h11, 8'h22, 8'h33, 8'h44);
        s_data = 32'h88776655;
        set_readys(4'b1011);
        #1;
        check("t3 s_ready stall", {31'd0, s_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_lanes($sformatf("t3 stall %0d", k), 4'b0100, 8'h11, 8'h22, 8'h33, 8'h44);
            check($sformatf("t3 s_ready %0d", k), {31'd0, s_ready}, 32'd0);
        end
        set_readys(4'hF);
        #1;
        check("t3 s_ready release", {31'd0, s_ready}, 32'd1);
        tick();
        s_valid = 1'b0;
        check_lanes("t3 second", 4'hF, 8'h55, 8'h66, 8'h77, 8'h88);
        check("t3 cnt", {16'd0, accept_cnt}, 32'd2);
        tick();
        check("t3 idle", {28'd0, d_valid, c_valid, b_valid, a_valid}, 32'd0);

        // 4: all lanes stalled with s_valid held
        do_reset();
        s_data  = 32'hD4C3B2A1;
        s_valid = 1'b1;
        tick();
        s_data = 32'h5A4B3C2D;
        set_readys(4'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("t4 s_ready %0d", k), {31'd0, s_ready}, 32'd0);
            tick();
            check_lanes($sformatf("t4 hold %0d", k), 4'hF, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
            check($sformatf("t4 cnt %0d", k), {16'd0, accept_cnt}, 32'd1);
        end
        set_readys(4'hF);
        #1;
        check("t4 s_ready release", {31'd0, s_ready}, 32'd1);
        tick();
        s_valid = 1'b0;
        check_lanes("t4 second", 4'hF, 8'h2D, 8'h3C, 8'h4B, 8'h5A);
        check("t4 cnt after", {16'd0, accept_cnt}, 32'd2);
        tick();
        check("t4 idle", {28'd0, d_valid, c_valid, b_valid, a_valid}, 32'd0);
        check("t4 no dup", {16'd0, accept_cnt}, 32'd2);

        // 5: reset while full and stalled
        s_data  = 32'h99AABBCC;
        s_valid = 1'b1;
        tick();
        set_readys(4'h0);
        tick();
        check_lanes("t5 full", 4'hF, 8'hCC, 8'hBB, 8'hAA, 8'h99);
        reset = 1'b0;
        set_readys(4'hF);
        #1;
        check("t5 s_ready in rst", {31'd0, s_ready}, 32'd0);
        tick();
        check_lanes("t5 cleared", 4'h0, 8'd0, 8'd0, 8'd0, 8'd0);
        check("t5 cnt", {16'd0, accept_cnt}, 32'd0);
        check("t5 s_ready still rst", {31'd0, s_ready}, 32'd0);
        s_valid = 1'b0;
        reset   = 1'b1;
        #1;
        check("t5 s_ready out of rst", {31'd0, s_ready}, 32'd1);

        // 6: counter wrap
        do_reset();
        s_data  = 32'h01020304;
        s_valid = 1'b1;
        for (int k = 0; k < 65535; k++) tick();
        check("t6 cnt max", {16'd0, accept_cnt}, 32'h0000FFFF);
        s_data = 32'hF0E0D0C0;
        tick();
        s_valid = 1'b0;
        check("t6 cnt wrap", {16'd0, accept_cnt}, 32'd0);
        check_lanes("t6 data", 4'hF, 8'hC0, 8'hD0, 8'hE0, 8'hF0);
        tick();
        check("t6 idle", {28'd0, d_valid, c_valid, b_valid, a_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
